// File: rtl/rs232_pkg.sv
// Shared RS232 definitions: FSM encoding and baud divider helpers.
// The divider helpers are also used by the RX deserializer.
package rs232_pkg;

  // Serializer FSM encoding
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_START = 3'd3,
    S_DATA  = 3'd4,
    S_STOP  = 3'd5
  } state_t;

  // Clocks per bit, rounded to nearest
  function automatic int div_round(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

  // Width of a counter spanning 0..div-1
  function automatic int div_cnt_w(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/rs232_ser_if.sv
// TX FIFO read port, CTS# input and serial line of the RS232 serializer.
interface rs232_ser_if;
  logic [7:0] tx_fifo_data;
  logic       tx_fifo_empty;
  logic       tx_fifo_rd_en;
  logic       cts_n;
  logic       tx;
  logic       busy;

  // master: the serializer
  modport master (
    input  tx_fifo_data, tx_fifo_empty, cts_n,
    output tx_fifo_rd_en, tx, busy
  );

  // slave: FIFO / host side
  modport slave (
    output tx_fifo_data, tx_fifo_empty, cts_n,
    input  tx_fifo_rd_en, tx, busy
  );
endinterface

// File: rtl/rs232_ser_sync2.sv
// Two-flop synchronizer with configurable reset value.
module rs232_ser_sync2 #(
  parameter logic P_RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_s1;
  logic r_s2;

  // Double-register the asynchronous input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= P_RST_VAL;
      r_s2 <= P_RST_VAL;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;

endmodule

// File: rtl/rs232_ser.sv
// RS232 8N1 transmit serializer fed by a non-show-ahead TX FIFO.
// One byte is popped per frame; CTS# is only honoured between frames.
module rs232_ser
  import rs232_pkg::*;
#(
  parameter int P_CLK_FREQ_HZ = 50000000,
  parameter int P_BAUD_RATE   = 115200
) (
  input logic         clk,
  input logic         rst_n,
  rs232_ser_if.master bus
);

  // Derived from the clock and baud parameters only
  localparam int              P_DIV  = div_round(P_CLK_FREQ_HZ, P_BAUD_RATE);
  localparam int              CW     = div_cnt_w(P_DIV);
  localparam logic [CW-1:0]   C_LAST = CW'(P_DIV - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_baud;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic [7:0]    w_shift_nxt;
  logic          w_bit_end;
  logic          w_cts_sync;
  logic          w_cts_ok;
  logic          r_tx;
  logic          r_rd_en;
  logic          r_busy;
  logic          w_tx_nxt;
  logic          w_rd_nxt;
  logic          w_busy_nxt;

  rs232_ser_sync2 #(.P_RST_VAL(1'b1)) u_cts_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (bus.cts_n),
    .o_q   (w_cts_sync)
  );

  assign w_cts_ok  = ~w_cts_sync;
  assign w_bit_end = (r_baud == C_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state: frame sequencing, CTS and empty looked at only in IDLE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (!bus.tx_fifo_empty && w_cts_ok) w_state_nxt = S_FETCH;
      S_FETCH: w_state_nxt = S_LOAD;
      S_LOAD:  w_state_nxt = S_START;
      S_START: if (w_bit_end) w_state_nxt = S_DATA;
      S_DATA:  if (w_bit_end && r_bit == 3'd7) w_state_nxt = S_STOP;
      S_STOP:  if (w_bit_end) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Shift register next value: load in LOAD, shift right at each data bit end
  always_comb begin
    w_shift_nxt = r_shift;
    if (r_state == S_LOAD)                   w_shift_nxt = bus.tx_fifo_data;
    else if (r_state == S_DATA && w_bit_end) w_shift_nxt = {1'b0, r_shift[7:1]};
  end

  // Output decode from the next state so every output leaves a flop
  always_comb begin
    w_rd_nxt   = (w_state_nxt == S_FETCH);
    w_busy_nxt = (w_state_nxt != S_IDLE);
    case (w_state_nxt)
      S_START: w_tx_nxt = 1'b0;
      S_DATA:  w_tx_nxt = w_shift_nxt[0];
      default: w_tx_nxt = 1'b1;
    endcase
  end

  // Registered outputs; reset drives the line back to mark immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx    <= 1'b1;
      r_rd_en <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_tx    <= w_tx_nxt;
      r_rd_en <= w_rd_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  // Baud counter, bit counter and shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_baud  <= '0;
      r_bit   <= 3'd0;
      r_shift <= 8'h00;
    end else begin
      r_shift <= w_shift_nxt;
      case (r_state)
        S_LOAD: begin
          r_baud <= '0;
          r_bit  <= 3'd0;
        end
        S_START, S_STOP: r_baud <= w_bit_end ? '0 : r_baud + CW'(1);
        S_DATA: begin
          r_baud <= w_bit_end ? '0 : r_baud + CW'(1);
          if (w_bit_end) r_bit <= r_bit + 3'd1;
        end
        default: r_baud <= '0;
      endcase
    end
  end

  assign bus.tx            = r_tx;
  assign bus.tx_fifo_rd_en = r_rd_en;
  assign bus.busy          = r_busy;

endmodule
